// File: rtl/sequence_generator_if.sv
// Load handshake and serial output bundle for sequence_generator.
// master: pattern source / checker side, slave: the generator.
interface sequence_generator_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             X;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             expect_z;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output load_valid, data_in,
    input  load_ready, X, x_valid, busy, done, expect_z, match_cnt
  );

  modport slave (
    input  load_valid, data_in,
    output load_ready, X, x_valid, busy, done, expect_z, match_cnt
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: accepts a WIDTH-bit word over a valid/ready
// handshake and shifts it out MSB-first with a bit-valid strobe and an
// end-of-word pulse. Optional golden Mealy detector for 10011 (overlapping)
// is built when SEQGEN_GOLDEN_EN is defined; otherwise expect_z/match_cnt
// are tied to zero.
module sequence_generator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  sequence_generator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic             accept;
  logic             x;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and load acceptance
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_valid) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bitcnt == BW'(WIDTH - 1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift register and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (accept) begin
      shreg  <= bus.data_in;
      bitcnt <= '0;
    end else if (state == SHIFT) begin
      shreg  <= {shreg[WIDTH-2:0], 1'b0};
      bitcnt <= bitcnt + 1'b1;
    end
  end

  assign x           = (state == SHIFT) & shreg[WIDTH-1];
  assign bus.X       = x;
  assign bus.x_valid = (state == SHIFT);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.load_ready = (state == IDLE);

`ifdef SEQGEN_GOLDEN_EN
  logic [3:0]       hist;
  logic [CNT_W-1:0] cnt;
  logic             z;

  // hist sees every cycle's X, so idle zeros break patterns across words
  assign z = (hist == 4'b1001) & x;

  // Golden history and match counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      cnt  <= '0;
    end else begin
      hist <= {hist[2:0], x};
      if (z) cnt <= cnt + 1'b1;
    end
  end

  assign bus.expect_z  = z;
  assign bus.match_cnt = cnt;
`else
  assign bus.expect_z  = 1'b0;
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_sequence_generator;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
`ifdef SEQGEN_GOLDEN_EN
  localparam bit GOLD = 1'b1;
`else
  localparam bit GOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sequence_generator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  sequence_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a schedule of upcoming output cycles, filled when a
  // word is accepted, plus the last four emitted X values for the golden check.
  typedef struct packed {logic x; logic xv; logic dn;} slot_t;
  slot_t       sched[$];
  bit          stream[$];
  int unsigned mcnt;

  // Observation log for the directed scenarios (rel = cycles since start)
  int rel;
  int zpos[$];
  int dpos[$];
  int ones[$];
  int xvcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_x();
    return (sched.size() != 0) ? bit'(sched[0].x) : 1'b0;
  endfunction

  function automatic bit exp_z();
    return GOLD && stream.size() == 4 && stream[0] && !stream[1] &&
           !stream[2] && stream[3] && exp_x();
  endfunction

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic model_clear();
    sched.delete();
    stream.delete();
    mcnt = 0;
  endtask

  task automatic model_edge(input bit lv, input logic [WIDTH-1:0] data);
    bit cx;
    cx = exp_x();
    if (exp_z()) mcnt = (mcnt + 1) % (1 << CNT_W);
    stream.push_back(cx);
    if (stream.size() > 4) void'(stream.pop_front());
    if (sched.size() != 0) begin
      void'(sched.pop_front());
    end else if (lv) begin
      for (int i = WIDTH - 1; i >= 0; i--) sched.push_back('{x: data[i], xv: 1'b1, dn: 1'b0});
      sched.push_back('{x: 1'b0, xv: 1'b0, dn: 1'b1});
    end
  endtask

  task automatic check_all();
    check("X",          32'(bus.X),          32'(exp_x()));
    check("x_valid",    32'(bus.x_valid),    32'(sched.size() != 0 && sched[0].xv));
    check("done",       32'(bus.done),       32'(sched.size() != 0 && sched[0].dn));
    check("busy",       32'(bus.busy),       32'(sched.size() != 0));
    check("load_ready", 32'(bus.load_ready), 32'(sched.size() == 0));
    check("expect_z",   32'(bus.expect_z),   32'(exp_z()));
    check("match_cnt",  32'(bus.match_cnt),  mcnt);
  endtask

  task automatic clear_obs();
    rel = 0;
    zpos.delete();
    dpos.delete();
    ones.delete();
    xvcnt = 0;
  endtask

  // Drive inputs, take one clock edge, then check one time unit later
  task automatic step(input bit lv, input logic [WIDTH-1:0] data);
    bus.load_valid = lv;
    bus.data_in    = data;
    @(posedge clk);
    if (reset) model_edge(lv, data);
    #1;
    check_all();
    rel++;
    if (bus.expect_z) zpos.push_back(rel);
    if (bus.done) dpos.push_back(rel);
    if (bus.x_valid && bus.X) ones.push_back(rel);
    if (bus.x_valid) xvcnt++;
  endtask

  // Asynchronous reset in the middle of a cycle, held for 'hold' edges
  task automatic pulse_reset(input int unsigned hold, input bit lv, input logic [WIDTH-1:0] data);
    #2 reset = 1'b0;
    model_clear();
    #1 check_all();
    for (int unsigned i = 0; i < hold; i++) step(lv, data);
    reset = 1'b1;
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.data_in    = '0;
    model_clear();
    clear_obs();
    #1 check_all();
    step(1'b1, 16'hFFFF);
    step(1'b0, '0);
    reset = 1'b1;

    // Idle after reset
    repeat (5) step(1'b0, '0);
    check("idle_cnt", 32'(bus.match_cnt), 32'd0);

    // 16'h9800: single match at k+5, done at k+17
    clear_obs();
    step(1'b1, 16'h9800);
    repeat (17) step(1'b0, '0);
    check("9800_nz",   32'(zpos.size()), GOLD ? 32'd1 : 32'd0);
    check("9800_zpos", 32'(qget(zpos, 0)), GOLD ? 32'd5 : 32'hFFFF_FFFF);
    check("9800_done", 32'(qget(dpos, 0)), 32'd17);
    check("9800_cnt",  32'(bus.match_cnt), GOLD ? 32'd1 : 32'd0);

    // 16'h9980: overlapping matches at k+5 and k+9
    clear_obs();
    step(1'b1, 16'h9980);
    repeat (17) step(1'b0, '0);
    check("9980_nz",  32'(zpos.size()), GOLD ? 32'd2 : 32'd0);
    check("9980_z0",  32'(qget(zpos, 0)), GOLD ? 32'd5 : 32'hFFFF_FFFF);
    check("9980_z1",  32'(qget(zpos, 1)), GOLD ? 32'd9 : 32'hFFFF_FFFF);
    check("9980_cnt", 32'(bus.match_cnt), GOLD ? 32'd3 : 32'd0);

    // 16'h0009 then 16'h8000 as soon as ready: idle zeros break the pattern
    clear_obs();
    step(1'b1, 16'h0009);
    for (int j = 1; j <= 18; j++) step(1'b1, 16'h8000);
    repeat (18) step(1'b0, '0);
    check("sep_nz",    32'(zpos.size()), 32'd0);
    check("sep_first", 32'(qget(ones, 2)), 32'd19);
    check("sep_words", 32'(dpos.size()), 32'd2);

    // load_valid held high with 16'hFFFF across two word slots
    clear_obs();
    for (int j = 0; j < 36; j++) step(1'b1, 16'hFFFF);
    repeat (20) step(1'b0, '0);
    check("hold_ndone", 32'(dpos.size()), 32'd2);
    check("hold_d0",    32'(qget(dpos, 0)), 32'd17);
    check("hold_d1",    32'(qget(dpos, 1)), 32'd35);
    check("hold_xv",    32'(xvcnt), 32'd32);
    check("hold_nz",    32'(zpos.size()), 32'd0);

    // Reset during cycle k+7 of a 16'h9980 transfer, load_valid high at release
    clear_obs();
    step(1'b1, 16'h9980);
    repeat (6) step(1'b0, '0);
    pulse_reset(2, 1'b1, 16'h9980);
    check("rst_cnt", 32'(bus.match_cnt), 32'd0);
    clear_obs();
    step(1'b1, 16'h9980);
    repeat (18) step(1'b0, '0);
    check("rst_xv",   32'(xvcnt), 32'd16);
    check("rst_first", 32'(qget(ones, 0)), 32'd1);
    check("rst_done", 32'(qget(dpos, 0)), 32'd17);
    check("rst_cnt2", 32'(bus.match_cnt), GOLD ? 32'd2 : 32'd0);

    // Randomized traffic with pattern-rich words and occasional resets
    for (int n = 0; n < 1500; n++) begin
      logic [WIDTH-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = WIDTH'($urandom);
        1:       d = 16'h9999 ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        2:       d = 16'h4CE6 ^ WIDTH'($urandom & $urandom & $urandom);
        default: d = 16'h9800 >> $urandom_range(0, 11);
      endcase
      if ($urandom_range(0, 199) == 0)
        pulse_reset($urandom_range(1, 2), $urandom_range(0, 1) == 1, d);
      else
        step($urandom_range(0, 2) != 0, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
